multi_ctrl: RTL and testbench
=============================

MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (system clock, rising edge); rst input 1 (reset); Op input 6 (IR[31:26]); Funct input 6 (IR[5:0]); Zero input 1 (ALU zero flag).
REQ-002 SHALL have outputs: PCWrite 1; IRWrite 1; MemWrite 1; IorD 1 (0=PC, 1=ALUOut); RegWrite 1; RegDst 2 (0=rt, 1=rd, 2=r31); WDSel 2 (0=ALUOut, 1=MDR, 2=PC); ALUSrcA 1 (0=PC, 1=rs); ALUSrcB 2 (0=rt, 1=const 4, 2=ext imm, 3=sign-ext imm<<2); EXTOp 1 (1=sign, 0=zero); PCSource 2 (0=ALU, 1=ALUOut, 2=jump target, 3=rs); ALUOp 4 (ALU_* codes of ctrl_encode_def.v); State 3 (current state); Illegal 1.
REQ-003 One clock, clk; rst is synchronous, active-high.

Function
REQ-004 SHALL be a five-state Moore FSM: IF=0, ID=1, EXE=2, MEM=3, WB=4; outputs decode only State, Op, Funct, Zero.
REQ-005 Unlisted outputs SHALL be 0 in each state; ALUOp defaults to ALU_NOP.
REQ-006 IF: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ALU_ADD, PCWrite=1, PCSource=0; next ID.
REQ-007 ID: ALUSrcA=0, ALUSrcB=3, ALUOp=ALU_ADD (branch target into ALUOut).
REQ-008 ID, j (Op 0x02): PCWrite=1, PCSource=2; next IF.
REQ-009 ID, jal (Op 0x03): PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, WDSel=2 (PC already +4); next IF.
REQ-010 ID, Op/Funct not in REQ-011..013: Illegal=1 for that one cycle, no write strobe; next IF.
REQ-011 R-type (Op 0): Funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x00 SHIFTL, 0x02 SHIFTR, 0x04 SHIFTLV, 0x06 SHIFTRV, 0x08 jr.
REQ-012 I-type: lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F.
REQ-013 EXE, R-type except jr: ALUSrcA=1, ALUSrcB=0, ALUOp per REQ-011; next WB.
REQ-014 EXE, jr: PCWrite=1, PCSource=3; next IF.
REQ-015 EXE, lw/sw: ALUSrcA=1, ALUSrcB=2, EXTOp=1, ALU_ADD; next MEM.
REQ-016 EXE, beq: ALUSrcA=1, ALUSrcB=0, ALU_SUB, PCSource=1, PCWrite=Zero; bne identical with PCWrite=~Zero; next IF.
REQ-017 EXE, I-ALU: ALUSrcA=1, ALUSrcB=2; addi ADD EXTOp=1; slti SLT EXTOp=1; andi AND EXTOp=0; ori OR EXTOp=0; lui SHIFT16 EXTOp=0; next WB.
REQ-018 MEM: IorD=1; sw MemWrite=1 then IF; lw then WB.
REQ-019 WB: RegWrite=1; R-type RegDst=1, WDSel=0; I-ALU RegDst=0, WDSel=0; lw RegDst=0, WDSel=1; next IF.
REQ-020 Illegal state encodings 5-7 SHALL return to IF next cycle, all strobes 0.
REQ-021 Cycle counts: j/jal 2; beq/bne/jr 3; sw 4; R/I-ALU 4; lw 5.

Reset
REQ-022 rst=1 at a rising clk edge SHALL load State=IF, regardless of current state, including mid-instruction.
REQ-023 While rst=1, PCWrite, IRWrite, MemWrite, RegWrite SHALL be forced 0 and Illegal 0; other outputs may follow State.
REQ-024 First cycle after rst deasserts SHALL be IF with REQ-006 outputs.

Verification
REQ-025 Reset then Op=0, Funct=0x20: State 0,1,2,4,0; EXE ALUOp=ALU_ADD, ALUSrcA=1; WB RegWrite=1, RegDst=1, WDSel=0.
REQ-026 lw (Op 0x23): State 0,1,2,3,4; MEM IorD=1, MemWrite=0; WB WDSel=1, RegDst=0; sw (0x2B): MEM MemWrite=1, next State=0.
REQ-027 beq with Zero=1 then Zero=0: EXE PCWrite=1 then 0, PCSource=1; bne inverse; both return to IF after EXE.
REQ-028 jal: ID PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, WDSel=2; next IF; Op=0x3F: ID Illegal=1 single cycle, no strobes, next IF.
REQ-029 rst=1 while in MEM of sw: that cycle MemWrite=0; next State=0; normal IF follows deassert.
REQ-030 ori (0x0D) EXTOp=0 ALU_OR; lui (0x0F) ALU_SHIFT16; sll Funct 0x00 ALU_SHIFTL; all WB RegDst as REQ-019.

Source files
------------

// File: rtl/multi_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the multi-cycle controller.
interface multi_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite;
    logic       IRWrite;
    logic       MemWrite;
    logic       IorD;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] WDSel;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       EXTOp;
    logic [1:0] PCSource;
    logic [3:0] ALUOp;
    logic [2:0] State;
    logic       Illegal;

    modport master (
        output Op, Funct, Zero,
        input  PCWrite, IRWrite, MemWrite, IorD, RegWrite, RegDst, WDSel,
               ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp, State, Illegal
    );

    modport slave (
        input  Op, Funct, Zero,
        output PCWrite, IRWrite, MemWrite, IorD, RegWrite, RegDst, WDSel,
               ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp, State, Illegal
    );
endinterface

// File: rtl/multi_ctrl.sv
// Five-state multi-cycle MIPS controller (IF/ID/EXE/MEM/WB); outputs decode state, opcode, funct and Zero.
module multi_ctrl (
    input  logic       clk,
    input  logic       rst,
    multi_ctrl_if.slave bus
);
    localparam logic [3:0] ALU_NOP     = 4'd0;
    localparam logic [3:0] ALU_ADD     = 4'd1;
    localparam logic [3:0] ALU_SUB     = 4'd2;
    localparam logic [3:0] ALU_AND     = 4'd3;
    localparam logic [3:0] ALU_OR      = 4'd4;
    localparam logic [3:0] ALU_SLT     = 4'd5;
    localparam logic [3:0] ALU_SLTU    = 4'd6;
    localparam logic [3:0] ALU_NOR     = 4'd7;
    localparam logic [3:0] ALU_SHIFTL  = 4'd8;
    localparam logic [3:0] ALU_SHIFTR  = 4'd9;
    localparam logic [3:0] ALU_SHIFTLV = 4'd10;
    localparam logic [3:0] ALU_SHIFTRV = 4'd11;
    localparam logic [3:0] ALU_SHIFT16 = 4'd12;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       is_r, r_ok, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic       is_ialu, i_ext, legal;
    logic [3:0] r_alu, i_alu;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        r_alu   = ALU_NOP;
        r_ok    = 1'b1;
        case (bus.Funct)
            6'h20:   r_alu = ALU_ADD;
            6'h22:   r_alu = ALU_SUB;
            6'h24:   r_alu = ALU_AND;
            6'h25:   r_alu = ALU_OR;
            6'h27:   r_alu = ALU_NOR;
            6'h2A:   r_alu = ALU_SLT;
            6'h2B:   r_alu = ALU_SLTU;
            6'h00:   r_alu = ALU_SHIFTL;
            6'h02:   r_alu = ALU_SHIFTR;
            6'h04:   r_alu = ALU_SHIFTLV;
            6'h06:   r_alu = ALU_SHIFTRV;
            6'h08:   r_alu = ALU_NOP;
            default: r_ok  = 1'b0;
        endcase
        i_alu   = ALU_NOP;
        i_ext   = 1'b0;
        is_ialu = 1'b1;
        case (bus.Op)
            6'h08:   begin i_alu = ALU_ADD; i_ext = 1'b1; end
            6'h0A:   begin i_alu = ALU_SLT; i_ext = 1'b1; end
            6'h0C:   i_alu = ALU_AND;
            6'h0D:   i_alu = ALU_OR;
            6'h0F:   i_alu = ALU_SHIFT16;
            default: is_ialu = 1'b0;
        endcase
        is_r   = (bus.Op == 6'h00);
        is_jr  = is_r && (bus.Funct == 6'h08);
        is_lw  = (bus.Op == 6'h23);
        is_sw  = (bus.Op == 6'h2B);
        is_beq = (bus.Op == 6'h04);
        is_bne = (bus.Op == 6'h05);
        is_j   = (bus.Op == 6'h02);
        is_jal = (bus.Op == 6'h03);
        legal  = (is_r && r_ok) || is_lw || is_sw || is_beq || is_bne || is_ialu;
    end

    always_comb begin
        state_d      = S_IF;
        bus.PCWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IorD     = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 2'd0;
        bus.WDSel    = 2'd0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'd0;
        bus.EXTOp    = 1'b0;
        bus.PCSource = 2'd0;
        bus.ALUOp    = ALU_NOP;
        bus.Illegal  = 1'b0;
        case (state_q)
            S_IF: begin
                bus.IRWrite = 1'b1;
                bus.ALUSrcB = 2'd1;
                bus.ALUOp   = ALU_ADD;
                bus.PCWrite = 1'b1;
                state_d     = S_ID;
            end
            S_ID: begin
                bus.ALUSrcB = 2'd3;
                bus.ALUOp   = ALU_ADD;
                if (is_j || is_jal) begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'd2;
                    if (is_jal) begin
                        bus.RegWrite = 1'b1;
                        bus.RegDst   = 2'd2;
                        bus.WDSel    = 2'd2;
                    end
                end else if (legal) begin
                    state_d = S_EXE;
                end else begin
                    bus.Illegal = 1'b1;
                end
            end
            S_EXE: begin
                if (is_jr) begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'd3;
                end else if (is_r) begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = r_alu;
                    state_d     = S_WB;
                end else if (is_lw || is_sw) begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'd2;
                    bus.EXTOp   = 1'b1;
                    bus.ALUOp   = ALU_ADD;
                    state_d     = S_MEM;
                end else if (is_beq || is_bne) begin
                    bus.ALUSrcA  = 1'b1;
                    bus.ALUOp    = ALU_SUB;
                    bus.PCSource = 2'd1;
                    bus.PCWrite  = is_beq ? bus.Zero : ~bus.Zero;
                end else if (is_ialu) begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'd2;
                    bus.EXTOp   = i_ext;
                    bus.ALUOp   = i_alu;
                    state_d     = S_WB;
                end
            end
            S_MEM: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = is_sw;
                if (is_lw) state_d = S_WB;
            end
            S_WB: begin
                bus.RegWrite = is_r || is_ialu || is_lw;
                bus.RegDst   = is_r ? 2'd1 : 2'd0;
                bus.WDSel    = is_lw ? 2'd1 : 2'd0;
            end
            default: state_d = S_IF;
        endcase
        // reset masks every write strobe, whatever the current state decodes to
        if (rst) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.RegWrite = 1'b0;
            bus.Illegal  = 1'b0;
        end
    end

    assign bus.State = state_q;
endmodule

// File: tb/tb_multi_ctrl.sv
// Scoreboard bench for multi_ctrl: directed per-cycle expectations queued by stimulus, checked by a monitor.
module tb_multi_ctrl;
    localparam int NOP = 0, ADD = 1, SUB = 2, AND_ = 3, OR_ = 4, SLT = 5;
    localparam int SHL = 8, S16 = 12;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, mw, iord, rw;
        logic [1:0] rdst, wds;
        logic       asa;
        logic [1:0] asb;
        logic       ext;
        logic [1:0] pcs;
        logic [3:0] alu;
        logic       ill;
    } outv_t;

    typedef struct {
        outv_t v;
        string nm;
    } item_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    item_t q[$];
    int    total = 0;
    int    bad = 0;

    multi_ctrl_if bus ();
    multi_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic outv_t ev(int st, int pcw, int irw, int mw, int iord, int rw,
                                 int rdst, int wds, int asa, int asb, int ext, int pcs,
                                 int alu, int ill);
        outv_t r;
        r.st = 3'(st);   r.pcw = 1'(pcw); r.irw = 1'(irw); r.mw = 1'(mw);
        r.iord = 1'(iord); r.rw = 1'(rw); r.rdst = 2'(rdst); r.wds = 2'(wds);
        r.asa = 1'(asa); r.asb = 2'(asb); r.ext = 1'(ext); r.pcs = 2'(pcs);
        r.alu = 4'(alu); r.ill = 1'(ill);
        return r;
    endfunction

    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input outv_t e, input string nm);
        item_t it;
        @(posedge clk);
        #1;
        rst = r;
        bus.Op = op;
        bus.Funct = fn;
        bus.Zero = z;
        it.v = e;
        it.nm = nm;
        q.push_back(it);
    endtask

    initial begin
        item_t it;
        outv_t act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it = q.pop_front();
                act = {bus.State, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.IorD,
                       bus.RegWrite, bus.RegDst, bus.WDSel, bus.ALUSrcA, bus.ALUSrcB,
                       bus.EXTOp, bus.PCSource, bus.ALUOp, bus.Illegal};
                total++;
                if (act !== it.v) begin
                    bad++;
                    $display("FAIL %s: got=%h want=%h", it.nm, act, it.v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        outv_t v_if, v_rst, v_id, v_lsx;
        //          st pcw irw mw iord rw rdst wds asa asb ext pcs alu ill
        v_if  = ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, ADD, 0);
        v_rst = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ADD, 0);
        v_id  = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, ADD, 0);
        v_lsx = ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, ADD, 0);
        bus.Op = 6'h00; bus.Funct = 6'h20; bus.Zero = 1'b0;

        cyc(1, 6'h00, 6'h20, 0, v_rst, "reset0");
        cyc(1, 6'h00, 6'h20, 0, v_rst, "reset1");

        // add
        cyc(0, 6'h00, 6'h20, 0, v_if, "add_if");
        cyc(0, 6'h00, 6'h20, 0, v_id, "add_id");
        cyc(0, 6'h00, 6'h20, 0, ev(2, 0,0,0,0,0, 0,0, 1,0, 0,0, ADD, 0), "add_exe");
        cyc(0, 6'h00, 6'h20, 0, ev(4, 0,0,0,0,1, 1,0, 0,0, 0,0, NOP, 0), "add_wb");
        // lw
        cyc(0, 6'h23, 6'h00, 0, v_if, "lw_if");
        cyc(0, 6'h23, 6'h00, 0, v_id, "lw_id");
        cyc(0, 6'h23, 6'h00, 0, v_lsx, "lw_exe");
        cyc(0, 6'h23, 6'h00, 0, ev(3, 0,0,0,1,0, 0,0, 0,0, 0,0, NOP, 0), "lw_mem");
        cyc(0, 6'h23, 6'h00, 0, ev(4, 0,0,0,0,1, 0,1, 0,0, 0,0, NOP, 0), "lw_wb");
        // sw
        cyc(0, 6'h2B, 6'h00, 0, v_if, "sw_if");
        cyc(0, 6'h2B, 6'h00, 0, v_id, "sw_id");
        cyc(0, 6'h2B, 6'h00, 0, v_lsx, "sw_exe");
        cyc(0, 6'h2B, 6'h00, 0, ev(3, 0,0,1,1,0, 0,0, 0,0, 0,0, NOP, 0), "sw_mem");
        // beq taken / not taken, bne inverse
        cyc(0, 6'h04, 6'h00, 1, v_if, "beq1_if");
        cyc(0, 6'h04, 6'h00, 1, v_id, "beq1_id");
        cyc(0, 6'h04, 6'h00, 1, ev(2, 1,0,0,0,0, 0,0, 1,0, 0,1, SUB, 0), "beq_z1_exe");
        cyc(0, 6'h04, 6'h00, 0, v_if, "beq0_if");
        cyc(0, 6'h04, 6'h00, 0, v_id, "beq0_id");
        cyc(0, 6'h04, 6'h00, 0, ev(2, 0,0,0,0,0, 0,0, 1,0, 0,1, SUB, 0), "beq_z0_exe");
        cyc(0, 6'h05, 6'h00, 1, v_if, "bne1_if");
        cyc(0, 6'h05, 6'h00, 1, v_id, "bne1_id");
        cyc(0, 6'h05, 6'h00, 1, ev(2, 0,0,0,0,0, 0,0, 1,0, 0,1, SUB, 0), "bne_z1_exe");
        cyc(0, 6'h05, 6'h00, 0, v_if, "bne0_if");
        cyc(0, 6'h05, 6'h00, 0, v_id, "bne0_id");
        cyc(0, 6'h05, 6'h00, 0, ev(2, 1,0,0,0,0, 0,0, 1,0, 0,1, SUB, 0), "bne_z0_exe");
        // jal, j, illegal opcode, illegal funct
        cyc(0, 6'h03, 6'h00, 0, v_if, "jal_if");
        cyc(0, 6'h03, 6'h00, 0, ev(1, 1,0,0,0,1, 2,2, 0,3, 0,2, ADD, 0), "jal_id");
        cyc(0, 6'h02, 6'h00, 0, v_if, "j_if");
        cyc(0, 6'h02, 6'h00, 0, ev(1, 1,0,0,0,0, 0,0, 0,3, 0,2, ADD, 0), "j_id");
        cyc(0, 6'h3F, 6'h00, 0, v_if, "ill_if");
        cyc(0, 6'h3F, 6'h00, 0, ev(1, 0,0,0,0,0, 0,0, 0,3, 0,0, ADD, 1), "ill_op_id");
        cyc(0, 6'h00, 6'h3F, 0, v_if, "illf_if");
        cyc(0, 6'h00, 6'h3F, 0, ev(1, 0,0,0,0,0, 0,0, 0,3, 0,0, ADD, 1), "ill_fn_id");
        // jr
        cyc(0, 6'h00, 6'h08, 0, v_if, "jr_if");
        cyc(0, 6'h00, 6'h08, 0, v_id, "jr_id");
        cyc(0, 6'h00, 6'h08, 0, ev(2, 1,0,0,0,0, 0,0, 0,0, 0,3, NOP, 0), "jr_exe");
        // ori, lui, sll, addi, slti, andi
        cyc(0, 6'h0D, 6'h00, 0, v_if, "ori_if");
        cyc(0, 6'h0D, 6'h00, 0, v_id, "ori_id");
        cyc(0, 6'h0D, 6'h00, 0, ev(2, 0,0,0,0,0, 0,0, 1,2, 0,0, OR_, 0), "ori_exe");
        cyc(0, 6'h0D, 6'h00, 0, ev(4, 0,0,0,0,1, 0,0, 0,0, 0,0, NOP, 0), "ori_wb");
        cyc(0, 6'h0F, 6'h00, 0, v_if, "lui_if");
        cyc(0, 6'h0F, 6'h00, 0, v_id, "lui_id");
        cyc(0, 6'h0F, 6'h00, 0, ev(2, 0,0,0,0,0, 0,0, 1,2, 0,0, S16, 0), "lui_exe");
        cyc(0, 6'h0F, 6'h00, 0, ev(4, 0,0,0,0,1, 0,0, 0,0, 0,0, NOP, 0), "lui_wb");
        cyc(0, 6'h00, 6'h00, 0, v_if, "sll_if");
        cyc(0, 6'h00, 6'h00, 0, v_id, "sll_id");
        cyc(0, 6'h00, 6'h00, 0, ev(2, 0,0,0,0,0, 0,0, 1,0, 0,0, SHL, 0), "sll_exe");
        cyc(0, 6'h00, 6'h00, 0, ev(4, 0,0,0,0,1, 1,0, 0,0, 0,0, NOP, 0), "sll_wb");
        cyc(0, 6'h08, 6'h00, 0, v_if, "addi_if");
        cyc(0, 6'h08, 6'h00, 0, v_id, "addi_id");
        cyc(0, 6'h08, 6'h00, 0, ev(2, 0,0,0,0,0, 0,0, 1,2, 1,0, ADD, 0), "addi_exe");
        cyc(0, 6'h08, 6'h00, 0, ev(4, 0,0,0,0,1, 0,0, 0,0, 0,0, NOP, 0), "addi_wb");
        cyc(0, 6'h0A, 6'h00, 0, v_if, "slti_if");
        cyc(0, 6'h0A, 6'h00, 0, v_id, "slti_id");
        cyc(0, 6'h0A, 6'h00, 0, ev(2, 0,0,0,0,0, 0,0, 1,2, 1,0, SLT, 0), "slti_exe");
        cyc(0, 6'h0A, 6'h00, 0, ev(4, 0,0,0,0,1, 0,0, 0,0, 0,0, NOP, 0), "slti_wb");
        cyc(0, 6'h0C, 6'h00, 0, v_if, "andi_if");
        cyc(0, 6'h0C, 6'h00, 0, v_id, "andi_id");
        cyc(0, 6'h0C, 6'h00, 0, ev(2, 0,0,0,0,0, 0,0, 1,2, 0,0, AND_, 0), "andi_exe");
        cyc(0, 6'h0C, 6'h00, 0, ev(4, 0,0,0,0,1, 0,0, 0,0, 0,0, NOP, 0), "andi_wb");
        // sub, then reset asserted during sw MEM
        cyc(0, 6'h00, 6'h22, 0, v_if, "sub_if");
        cyc(0, 6'h00, 6'h22, 0, v_id, "sub_id");
        cyc(0, 6'h00, 6'h22, 0, ev(2, 0,0,0,0,0, 0,0, 1,0, 0,0, SUB, 0), "sub_exe");
        cyc(0, 6'h00, 6'h22, 0, ev(4, 0,0,0,0,1, 1,0, 0,0, 0,0, NOP, 0), "sub_wb");
        cyc(0, 6'h2B, 6'h00, 0, v_if, "swr_if");
        cyc(0, 6'h2B, 6'h00, 0, v_id, "swr_id");
        cyc(0, 6'h2B, 6'h00, 0, v_lsx, "swr_exe");
        cyc(1, 6'h2B, 6'h00, 0, ev(3, 0,0,0,1,0, 0,0, 0,0, 0,0, NOP, 0), "swr_mem_rst");
        cyc(0, 6'h2B, 6'h00, 0, v_if, "after_rst_if");
        cyc(0, 6'h2B, 6'h00, 0, v_id, "after_rst_id");

        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d want=0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
